// File: rtl/image_line_feeder_pkg.sv
// Shared definitions for the image line feeder and the 3x3 window generator:
// pixel width, default frame geometry and the feeder state encoding.
`timescale 1ns/1ps
package image_line_feeder_pkg;

  localparam int INTEGER_BITS_DEF     = 9;
  localparam int FIXED_POINT_BITS_DEF = 4;
  localparam int W                    = INTEGER_BITS_DEF + FIXED_POINT_BITS_DEF;
  localparam int LINE_WIDTH_DEF       = 512;
  localparam int NUM_LINES_DEF        = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } feeder_state_e;

  // Bits needed to hold the values 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/image_line_feeder_credit.sv
// line_credit_counter: saturating up/down count of lines the window generator
// can still absorb, with a sticky flag for an increment past the maximum.
`timescale 1ns/1ps
module line_credit_counter
  import image_line_feeder_pkg::*;
#(
  parameter int MAX = 4,
  parameter int CW  = cnt_width(MAX)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_load,
  input  logic          i_clr_err,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_credits,
  output logic          o_err
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] r_credits;
  logic          r_err;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credits <= '0;
      r_err     <= 1'b0;
    end else begin
      if (i_load) begin
        r_credits <= MAX_C;
      end else if (i_inc && !i_dec) begin
        if (r_credits == MAX_C) r_err <= 1'b1;
        else                    r_credits <= r_credits + 1'b1;
      end else if (i_dec && !i_inc && (r_credits != '0)) begin
        r_credits <= r_credits - 1'b1;
      end
      if (i_clr_err) r_err <= 1'b0;
    end
  end

  assign o_credits = r_credits;
  assign o_err     = r_err;

endmodule

// File: rtl/image_line_feeder.sv
// image_line_feeder: credit-based write-side flow control into the 3x3 window
// generator. Optional zero-pad lines above/below the frame: IMG_FEEDER_ZERO_PAD_EN.
`timescale 1ns/1ps
module image_line_feeder
  import image_line_feeder_pkg::*;
#(
  parameter int INTEGER_BITS     = INTEGER_BITS_DEF,
  parameter int FIXED_POINT_BITS = FIXED_POINT_BITS_DEF,
  parameter int LINE_WIDTH       = LINE_WIDTH_DEF,
  parameter int NUM_LINES        = NUM_LINES_DEF,
  parameter int PRIME_LINES      = 4
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_start,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] s_data,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] o_pixel_data,
  output logic                                     o_pixel_data_valid,
  input  logic                                     i_intr,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_err
);

  localparam int PW = INTEGER_BITS + FIXED_POINT_BITS;
`ifdef IMG_FEEDER_ZERO_PAD_EN
  localparam int FRAME_LINES = NUM_LINES + 2;
`else
  localparam int FRAME_LINES = NUM_LINES;
`endif
  localparam int EXP_INTR = FRAME_LINES - 2;
  localparam int COL_W    = cnt_width(LINE_WIDTH - 1);
  localparam int LINE_W   = cnt_width(FRAME_LINES);
  localparam int INTR_W   = cnt_width(EXP_INTR);
  localparam int CRED_W   = cnt_width(PRIME_LINES);

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_WIDTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(FRAME_LINES - 1);
  localparam logic [INTR_W-1:0] INTR_DONE = INTR_W'(EXP_INTR);
  localparam logic [CRED_W-1:0] CRED_ONE  = CRED_W'(1);

  feeder_state_e     r_state, w_state_next;
  logic [COL_W-1:0]  r_col;
  logic [LINE_W-1:0] r_lines;
  logic [INTR_W-1:0] r_intr_cnt, w_intr_cnt_next;
  logic [CRED_W-1:0] w_credits;
  logic [PW-1:0]     r_pix;
  logic              r_pix_vld, r_done;
  logic              w_pad_line, w_fire, w_line_end, w_frame_end;
  logic              w_start, w_intr_live, w_credit_inc, w_err;

`ifdef IMG_FEEDER_ZERO_PAD_EN
  assign w_pad_line = (r_lines == '0) || (r_lines == LINE_LAST);
`else
  assign w_pad_line = 1'b0;
`endif

  // Pad lines are self-generated, so they advance without upstream data.
  assign w_fire       = (r_state == SEND) && (w_pad_line || s_valid);
  assign w_line_end   = w_fire && (r_col == COL_LAST);
  assign w_frame_end  = w_line_end && (r_lines == LINE_LAST);
  assign w_start      = (r_state == IDLE) && i_start;
  assign w_intr_live  = i_intr && (r_state != IDLE);
  assign w_credit_inc = i_intr && ((r_state == SEND) || (r_state == WAIT));
  assign w_intr_cnt_next = (w_intr_live && (r_intr_cnt != INTR_DONE))
                         ? r_intr_cnt + 1'b1 : r_intr_cnt;

  line_credit_counter #(
    .MAX (PRIME_LINES),
    .CW  (CRED_W)
  ) u_credit (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_load    (w_start),
    .i_clr_err (w_start),
    .i_inc     (w_credit_inc),
    .i_dec     (w_line_end),
    .o_credits (w_credits),
    .o_err     (w_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // NOTE: the next state is defaulted to the current one before the case so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (i_start) w_state_next = SEND;
      SEND: begin
        if (w_frame_end)
          w_state_next = DRAIN;
        else if (w_line_end && !i_intr && (w_credits == CRED_ONE))
          w_state_next = WAIT;
      end
      WAIT:  if (i_intr) w_state_next = SEND;
      DRAIN: if (w_intr_cnt_next == INTR_DONE) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col      <= '0;
      r_lines    <= '0;
      r_intr_cnt <= '0;
      r_pix      <= '0;
      r_pix_vld  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_pix_vld <= w_fire;
      r_done    <= (r_state == DRAIN) && (w_state_next == IDLE);
      if (w_fire) r_pix <= w_pad_line ? '0 : s_data;
      if (w_start) begin
        r_col      <= '0;
        r_lines    <= '0;
        r_intr_cnt <= '0;
      end else begin
        r_intr_cnt <= w_intr_cnt_next;
        if (w_fire) begin
          r_col <= w_line_end ? '0 : r_col + 1'b1;
          if (w_line_end) r_lines <= r_lines + 1'b1;
        end
      end
    end
  end

  assign s_ready            = (r_state == SEND) && !w_pad_line;
  assign o_pixel_data       = r_pix;
  assign o_pixel_data_valid = r_pix_vld;
  assign o_busy             = (r_state != IDLE);
  assign o_done             = r_done;
  assign o_err              = w_err;

endmodule
